pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the five-stage core. It drives the stall (enable) and flush (clear) inputs of the IF/ID, ID/EX, EX/DM and DM/WB pipeline registers, and generates EX-stage operand-forwarding selects. It resolves four kinds of hazard:
- load-use data hazards
- taken branches/jumps
- data-memory wait states
- multi-cycle multiply occupancy in EX

Parameters:
MUL_LATENCY, 4, EX cycles a multiply occupies; legal range 2..16.
MEM_TIMEOUT, 255, consecutive data-memory wait cycles before a fault is raised; used only with the optional feature.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
d_rs1, d_rs2  in  `REG_ADDR_BUS  source registers of the instruction in decode
e_rs1, e_rs2  in  `REG_ADDR_BUS  source registers of the instruction in EX
e_rd  in  `REG_ADDR_BUS  destination register of the instruction in EX
e_is_load  in  1  EX instruction is a load
e_is_mul  in  1  EX instruction is a multiply
e_pcsrc  in  1  branch/jump taken, resolved in EX
m_rd, w_rd  in  `REG_ADDR_BUS  destination registers in DM and WB
m_regwrite, w_regwrite  in  1  DM/WB instruction writes the register file
m_mem_req  in  1  DM instruction accesses data memory
dmem_ack  in  1  data memory completes the access this cycle
f_stall, d_stall, e_stall, m_stall  out  1  hold PC / IF-ID / ID-EX / EX-DM registers (register enable = !stall)
d_flush, e_flush, m_flush, w_flush  out  1  clear IF-ID / ID-EX / EX-DM / DM-WB registers
fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 WB result, 10 DM ALU result
mul_busy  out  1  multiply in progress
mem_fault  out  1  data-memory timeout pulse

Behaviour:
- Reset (asynchronous): state=RUN, mul_cnt=0, tmo_cnt=0.
- While reset is high: all stall/flush outputs, mul_busy and mem_fault are 0. fwd_a/fwd_b stay combinational.
- Forwarding (combinational, zero latency):
  - fwd_a=10 if m_regwrite and m_rd!=0 and m_rd==e_rs1.
  - else fwd_a=01 if w_regwrite and w_rd!=0 and w_rd==e_rs1.
  - else fwd_a=00.
  - fwd_b uses the same rules with e_rs2.
  - DM wins over WB.
- mem_stall = m_mem_req and !dmem_ack (combinational).
  - Asserts f/d/e/m_stall and w_flush.
  - Suppresses every other flush and all state transitions except the mul_cnt decrement.
  - Has highest priority.
- FSM states: RUN, MUL.
- RUN:
  - Load-use: e_is_load and e_rd!=0 and (e_rd==d_rs1 or e_rd==d_rs2) -> f_stall, d_stall, e_flush.
  - Taken branch: e_pcsrc -> d_flush, e_flush, f_stall=0. A taken branch overrides load-use; no stall is issued.
  - Multiply: e_is_mul and !mem_stall -> enter MUL next edge with mul_cnt=MUL_LATENCY-2.
    - In this first cycle: f/d/e_stall=1 and m_flush=1.
    - A taken branch in EX cannot coexist with a multiply; decoder guarantees.
- MUL:
  - mul_busy=1.
  - mul_cnt decrements each cycle, saturating at 0.
  - While mul_cnt!=0 or mem_stall: f/d/e_stall=1 and m_flush=1 (unless mem_stall, which holds m instead).
  - When mul_cnt==0 and !mem_stall: release. No stall/flush; EX-DM captures the product. Next state RUN.
  - Total EX occupancy is exactly MUL_LATENCY cycles when no memory wait occurs.
- The multiply is not re-triggered on release: the ID-EX register advances at the same edge.
- Flush and stall asserted together on one register: flush wins. The register behaves as a cleared register.
- Asynchronous reset mid-MUL or mid-wait aborts to RUN. No output glitches beyond reset values.

Optional Feature:
PIPE_HAZARD_CTRL_MEM_TIMEOUT_EN.
- Defined:
  - tmo_cnt (8 bits) counts consecutive mem_stall cycles and resets to 0 whenever mem_stall is low.
  - When tmo_cnt==MEM_TIMEOUT and mem_stall is still high: mem_fault pulses for exactly 1 cycle.
  - In that cycle mem_stall is treated as released and m_flush plus w_flush squash the access.
  - tmo_cnt then returns to 0.
- Undefined: no counter is built, mem_fault is tied 0, and waits are unbounded.

Decomposition:
- Package pipe_ctrl_pkg:
  - ctrl_state_t enum {RUN, MUL}
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_DM=2'b10}
  - the MUL_LATENCY legal bounds
- One sub-module, fwd_select: combinational comparator for one operand, instantiated twice (fwd_a, fwd_b).

Test Plan:
- Load-use: EX lw x5, decode d_rs1=5 -> cycle 0: f_stall=d_stall=e_flush=1; next cycle: all 0.
- Forward priority: m_rd=w_rd=e_rs1=7, both regwrite -> fwd_a=10; m_rd=0, w_rd=e_rs1=0 -> fwd_a=00.
- Branch plus load-use in the same cycle: e_pcsrc=1 with a matching load -> d_flush=e_flush=1, f_stall=0.
- MUL_LATENCY=4, e_is_mul=1 -> f/d/e_stall=1 and m_flush=1 for cycles 0-2, mul_busy=1 for cycles 1-3, release in cycle 3.
- m_mem_req=1, dmem_ack=0 for 3 cycles during MUL -> all stalls held, w_flush=1; release delayed until ack and mul_cnt==0.
- With the macro and MEM_TIMEOUT=3: ack never arrives -> mem_fault single pulse on the 4th wait cycle, stalls drop, m_flush=w_flush=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer (package pipe_ctrl_pkg).
// Optional data-memory timeout is enabled with PIPE_HAZARD_CTRL_MEM_TIMEOUT_EN.
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif

package pipe_ctrl_pkg;

  typedef enum logic {
    RUN = 1'b0,
    MUL = 1'b1
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_WB = 2'b01,
    FWD_DM = 2'b10
  } fwd_sel_t;

  localparam int MUL_LATENCY_MIN = 2;
  localparam int MUL_LATENCY_MAX = 16;
  localparam int MUL_CNT_W       = 4;
  localparam int TMO_CNT_W       = 8;

  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic e_stall;
    logic m_stall;
    logic d_flush;
    logic e_flush;
    logic m_flush;
    logic w_flush;
    logic mul_busy;
    logic mem_fault;
  } ctrl_out_t;

  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [`REG_ADDR_BUS] rd,
                                     input logic [`REG_ADDR_BUS] rs);
    return (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Operand forwarding comparator for one EX source register; the DM stage
// result is younger than the WB result and therefore takes priority.
import pipe_ctrl_pkg::*;

module fwd_select (
  input  logic [`REG_ADDR_BUS] rs,
  input  logic [`REG_ADDR_BUS] m_rd,
  input  logic                 m_regwrite,
  input  logic [`REG_ADDR_BUS] w_rd,
  input  logic                 w_regwrite,
  output logic [1:0]           sel
);

  always_comb begin
    sel = FWD_RF;
    if (m_regwrite && reg_match(m_rd, rs)) begin
      sel = FWD_DM;
    end else if (w_regwrite && reg_match(w_rd, rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer with EX operand forwarding for the five-stage core.
// Define PIPE_HAZARD_CTRL_MEM_TIMEOUT_EN to build the data-memory wait timeout.
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [`REG_ADDR_BUS] d_rs1,
  input  logic [`REG_ADDR_BUS] d_rs2,
  input  logic [`REG_ADDR_BUS] e_rs1,
  input  logic [`REG_ADDR_BUS] e_rs2,
  input  logic [`REG_ADDR_BUS] e_rd,
  input  logic                 e_is_load,
  input  logic                 e_is_mul,
  input  logic                 e_pcsrc,
  input  logic [`REG_ADDR_BUS] m_rd,
  input  logic [`REG_ADDR_BUS] w_rd,
  input  logic                 m_regwrite,
  input  logic                 w_regwrite,
  input  logic                 m_mem_req,
  input  logic                 dmem_ack,
  output logic                 f_stall,
  output logic                 d_stall,
  output logic                 e_stall,
  output logic                 m_stall,
  output logic                 d_flush,
  output logic                 e_flush,
  output logic                 m_flush,
  output logic                 w_flush,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic                 mul_busy,
  output logic                 mem_fault
);

  if (MUL_LATENCY < MUL_LATENCY_MIN || MUL_LATENCY > MUL_LATENCY_MAX ||
      MEM_TIMEOUT < 0 || MEM_TIMEOUT > 255) begin : g_param_error
    $error("pipe_hazard_ctrl: MUL_LATENCY or MEM_TIMEOUT out of range");
  end

  localparam logic [MUL_CNT_W-1:0] MUL_INIT = MUL_CNT_W'(MUL_LATENCY - 2);

  ctrl_state_t          state;
  ctrl_state_t          state_next;
  logic [MUL_CNT_W-1:0] mul_cnt;
  logic [MUL_CNT_W-1:0] mul_cnt_next;
  logic                 mem_stall_raw;
  logic                 mem_stall;
  logic                 tmo_hit;
  logic                 load_use;
  ctrl_out_t            ctl;

  fwd_select u_fwd_a (
    .rs         (e_rs1),
    .m_rd       (m_rd),
    .m_regwrite (m_regwrite),
    .w_rd       (w_rd),
    .w_regwrite (w_regwrite),
    .sel        (fwd_a)
  );

  fwd_select u_fwd_b (
    .rs         (e_rs2),
    .m_rd       (m_rd),
    .m_regwrite (m_regwrite),
    .w_rd       (w_rd),
    .w_regwrite (w_regwrite),
    .sel        (fwd_b)
  );

  assign mem_stall_raw = m_mem_req & ~dmem_ack;

`ifdef PIPE_HAZARD_CTRL_MEM_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] tmo_cnt;

  assign tmo_hit = mem_stall_raw && (tmo_cnt == TMO_CNT_W'(MEM_TIMEOUT));

  // Counts consecutive wait cycles; the timeout cycle itself restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (mem_stall_raw && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // A timed-out access is abandoned, so the pipeline proceeds as if acked.
  assign mem_stall = mem_stall_raw & ~tmo_hit;

  assign load_use = e_is_load && (reg_match(e_rd, d_rs1) || reg_match(e_rd, d_rs2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      mul_cnt <= '0;
    end else begin
      state   <= state_next;
      mul_cnt <= mul_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    mul_cnt_next = mul_cnt;
    ctl          = '0;

    if (state == MUL) begin
      ctl.mul_busy = 1'b1;
      mul_cnt_next = (mul_cnt != '0) ? mul_cnt - 1'b1 : '0;
    end

    if (mem_stall) begin
      ctl.f_stall = 1'b1;
      ctl.d_stall = 1'b1;
      ctl.e_stall = 1'b1;
      ctl.m_stall = 1'b1;
      ctl.w_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (e_pcsrc) begin
            ctl.d_flush = 1'b1;
            ctl.e_flush = 1'b1;
          end else if (e_is_mul) begin
            ctl.f_stall  = 1'b1;
            ctl.d_stall  = 1'b1;
            ctl.e_stall  = 1'b1;
            ctl.m_flush  = 1'b1;
            state_next   = MUL;
            mul_cnt_next = MUL_INIT;
          end else if (load_use) begin
            ctl.f_stall = 1'b1;
            ctl.d_stall = 1'b1;
            ctl.e_flush = 1'b1;
          end
        end
        MUL: begin
          // On release the product flows into EX-DM and ID-EX takes the next instruction.
          if (mul_cnt != '0) begin
            ctl.f_stall = 1'b1;
            ctl.d_stall = 1'b1;
            ctl.e_stall = 1'b1;
            ctl.m_flush = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end

    if (tmo_hit) begin
      ctl.mem_fault = 1'b1;
      ctl.m_flush   = 1'b1;
      ctl.w_flush   = 1'b1;
    end
  end

  assign f_stall   = ctl.f_stall   & ~reset;
  assign d_stall   = ctl.d_stall   & ~reset;
  assign e_stall   = ctl.e_stall   & ~reset;
  assign m_stall   = ctl.m_stall   & ~reset;
  assign d_flush   = ctl.d_flush   & ~reset;
  assign e_flush   = ctl.e_flush   & ~reset;
  assign m_flush   = ctl.m_flush   & ~reset;
  assign w_flush   = ctl.w_flush   & ~reset;
  assign mul_busy  = ctl.mul_busy  & ~reset;
  assign mem_fault = ctl.mem_fault & ~reset;

endmodule
